// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared types for the RV32 instruction-fetch stage: cache request/response
// bundles, branch-unit PC select, decode-side fetch record and the bubble
// instruction substituted for faulted fetches.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int          FQ_DEPTH_DEFAULT = 2;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Canonical bubble inserted in place of a faulted fetch.
    localparam logic [31:0] Bubble = 32'h0000_4033;

    typedef enum logic [1:0] {
        PC_4     = 2'd0,
        PC_BRJMP = 2'd1,
        PC_JALR  = 2'd2,
        PC_EXC   = 2'd3
    } PcSel;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ICacheReq;

    typedef struct packed {
        logic [31:0] data;
        logic        data_block;
        logic        valid;
    } ICacheResp;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } FetchOut;

    // Instruction fetches are word aligned; low address bits are discarded.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO with flush, used for both the PC-tag queue and the
// fetch queue. Push and pop may happen together at any occupancy, including
// full. Flush empties the queue and takes priority over push/pop.
//   i_push/i_push_data : enqueue one entry
//   i_pop              : dequeue head (ignored when empty)
//   i_flush            : discard all entries
//   o_head             : current head entry (registered storage)
//   o_full/o_empty     : occupancy flags
//   o_count            : number of entries held
// -----------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);
    localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !i_flush) begin
            assert (!(i_push && !w_do_push))
                else $error("fetch_fifo: push into full queue");
            assert (!(i_pop && o_empty))
                else $error("fetch_fifo: pop from empty queue");
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the RV32 pipeline. Owns the fetch PC, issues
// cache requests under a credit limit, tags in-order cache responses with
// their PCs and queues them for decode. Branch-unit redirects flush both
// queues and mark every still-live request stale so its response is dropped.
//   clk, rst_n            : clock, async active-low reset
//   icache_req            : {valid, addr} request to the instruction cache
//   icache_req_ready      : cache accepts request on valid & ready
//   icache_resp           : {data, data_block, valid} in-order response
//   pc_sel                : redirect select (PC_4 = no redirect)
//   brjmp/jalr/exc_target : redirect targets
//   dec_valid/inst/pc/fault: fetch-queue head presented to decode
//   dec_ready             : decode consumes head on dec_valid & dec_ready
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output ICacheReq    icache_req,
    input  logic        icache_req_ready,
    input  ICacheResp   icache_resp,
    input  PcSel        pc_sel,
    input  logic [31:0] brjmp_target,
    input  logic [31:0] jalr_target,
    input  logic [31:0] exc_target,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic        dec_fault,
    input  logic        dec_ready
);
    localparam int            CW      = $clog2(FQ_DEPTH + 1);
    localparam logic [CW:0]   CREDITS = (CW + 1)'(FQ_DEPTH);
    localparam int            FQ_W    = 65;

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;
    logic          r_run;

    logic          w_redirect;
    logic [31:0]   w_target;
    logic          w_pop;
    logic [CW:0]   w_inflight;
    logic          w_req_valid;
    logic          w_accept;
    logic          w_resp;
    logic          w_resp_drop;
    logic          w_resp_keep;
    logic [CW-1:0] w_out_after_resp;

    logic [31:0]   w_tag_pc;
    logic          w_tag_full;
    logic          w_tag_empty;
    logic [CW-1:0] w_tag_count;

    logic [FQ_W-1:0] w_fq_push_data;
    logic [FQ_W-1:0] w_fq_head;
    logic            w_fq_full;
    logic            w_fq_empty;
    logic [CW-1:0]   w_fq_count;

    logic [31:0]   w_resp_inst;
    logic          w_resp_fault;
    FetchOut       w_head;

    assign w_redirect = (pc_sel != PC_4);

    always_comb begin
        w_target = 32'h0;
        unique case (pc_sel)
            PC_BRJMP: w_target = brjmp_target;
            PC_JALR:  w_target = jalr_target;
            PC_EXC:   w_target = exc_target;
            default:  w_target = 32'h0;
        endcase
    end

    assign w_pop = !w_fq_empty && dec_ready;

    // Credits cover queued entries plus every request in flight (stale ones
    // included), so a response can never find the fetch queue full.
    assign w_inflight  = {1'b0, r_outstanding} + {1'b0, w_fq_count}
                       - {{CW{1'b0}}, w_pop};
    assign w_req_valid = r_run && !w_redirect && (w_inflight < CREDITS);
    assign w_accept    = w_req_valid && icache_req_ready;

    // With nothing outstanding a response cannot belong to us (e.g. one that
    // was in flight across a reset), so it is ignored.
    assign w_resp      = icache_resp.valid && (r_outstanding != '0);
    assign w_resp_drop = w_resp && (r_drop != '0);
    assign w_resp_keep = w_resp && (r_drop == '0);

    assign w_out_after_resp = r_outstanding - CW'(w_resp);

    assign w_resp_inst    = icache_resp.data_block ? Bubble : icache_resp.data;
    assign w_resp_fault   = icache_resp.data_block;
    assign w_fq_push_data = {w_resp_inst, w_tag_pc, w_resp_fault};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_run         <= 1'b0;
        end else begin
            r_run         <= 1'b1;
            r_outstanding <= w_out_after_resp + CW'(w_accept);
            if (w_redirect) begin
                r_fetch_pc <= align_pc(w_target);
                r_drop     <= w_out_after_resp;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                r_drop <= r_drop - CW'(w_resp_drop);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (FQ_DEPTH),
        .CW    (CW)
    ) u_tag_q (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_accept),
        .i_push_data (r_fetch_pc),
        .i_pop       (w_resp_keep),
        .i_flush     (w_redirect),
        .o_head      (w_tag_pc),
        .o_full      (w_tag_full),
        .o_empty     (w_tag_empty),
        .o_count     (w_tag_count)
    );

    fetch_fifo #(
        .WIDTH (FQ_W),
        .DEPTH (FQ_DEPTH),
        .CW    (CW)
    ) u_fetch_q (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_resp_keep),
        .i_push_data (w_fq_push_data),
        .i_pop       (w_pop),
        .i_flush     (w_redirect),
        .o_head      (w_fq_head),
        .o_full      (w_fq_full),
        .o_empty     (w_fq_empty),
        .o_count     (w_fq_count)
    );

    always_comb begin
        w_head       = '0;
        w_head.valid = !w_fq_empty;
        if (!w_fq_empty) begin
            w_head.inst  = w_fq_head[64:33];
            w_head.pc    = w_fq_head[32:1];
            w_head.fault = w_fq_head[0];
        end
    end

    assign icache_req.valid = w_req_valid;
    assign icache_req.addr  = r_fetch_pc;

    assign dec_valid = w_head.valid;
    assign dec_inst  = w_head.inst;
    assign dec_pc    = w_head.pc;
    assign dec_fault = w_head.fault;

    // Live (non-stale) requests are exactly the entries of the tag queue.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (r_drop <= r_outstanding)
                else $error("fetch_stage: drop exceeds outstanding");
            assert (w_tag_count == (r_outstanding - r_drop))
                else $error("fetch_stage: tag queue out of step with credits");
            assert (!(w_accept && w_tag_full))
                else $error("fetch_stage: tag queue overflow");
            assert (!(w_resp_keep && w_tag_empty))
                else $error("fetch_stage: response without tag");
            assert (!(w_resp_keep && w_fq_full && !w_pop))
                else $error("fetch_stage: fetch queue overflow");
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RST_PC   = 32'h8000_0000;
    localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;
    localparam logic [31:0] BUBBLE_X = 32'h0000_4033;
    localparam int          DEPTH    = 2;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    ICacheReq    icache_req;
    logic        icache_req_ready = 1'b0;
    ICacheResp   icache_resp = '0;
    PcSel        pc_sel = PC_4;
    logic [31:0] brjmp_target = '0;
    logic [31:0] jalr_target = '0;
    logic [31:0] exc_target = '0;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_fault;
    logic        dec_ready = 1'b0;

    ICacheReq    wrap_req;
    ICacheResp   wrap_resp = '0;
    logic        wrap_dv, wrap_df;
    logic [31:0] wrap_di, wrap_dp;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .icache_req(icache_req), .icache_req_ready(icache_req_ready),
        .icache_resp(icache_resp), .pc_sel(pc_sel),
        .brjmp_target(brjmp_target), .jalr_target(jalr_target), .exc_target(exc_target),
        .dec_valid(dec_valid), .dec_inst(dec_inst), .dec_pc(dec_pc),
        .dec_fault(dec_fault), .dec_ready(dec_ready)
    );

    fetch_stage #(.RESET_PC(WRAP_PC), .FQ_DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .icache_req(wrap_req), .icache_req_ready(1'b1),
        .icache_resp(wrap_resp), .pc_sel(PC_4),
        .brjmp_target(32'h0), .jalr_target(32'h0), .exc_target(32'h0),
        .dec_valid(wrap_dv), .dec_inst(wrap_di), .dec_pc(wrap_dp),
        .dec_fault(wrap_df), .dec_ready(1'b1)
    );

    int vectors = 0;
    int miscompares = 0;

    // bench controls and model
    logic        c_ready = 1'b0;
    logic        c_dec_ready = 1'b0;
    PcSel        c_sel = PC_4;
    int          c_lat = 1;
    logic        fault_en = 1'b0;
    logic [31:0] fault_addr = '0;
    logic [31:0] m_pc = RST_PC;
    int          cyc = 0;
    pend_t       pending[$];
    exp_t        exp_q[$];
    logic        chk_first_en = 1'b0;
    logic [31:0] chk_first_pc = '0;
    logic        seen_fault = 1'b0;
    int          npops = 0;

    // values sampled during the last step
    logic        s_req_valid, s_acc, s_pop, s_resp, s_dec_valid;
    logic [31:0] s_req_addr, s_dec_inst;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic is_fault(input logic [31:0] a);
        return fault_en && (a == fault_addr);
    endfunction

    // One clock: drive inputs at negedge, sample 1 time unit later, update model.
    task automatic step();
        logic        redir;
        int          out_before;
        logic [31:0] tgt;
        exp_t        e;
        @(negedge clk);
        icache_req_ready = c_ready;
        dec_ready        = c_dec_ready;
        pc_sel           = c_sel;
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            icache_resp.valid      = 1'b1;
            icache_resp.data       = mem_data(pending[0].addr);
            icache_resp.data_block = is_fault(pending[0].addr);
        end else begin
            icache_resp = '0;
        end
        #1;
        redir       = (c_sel != PC_4);
        s_req_valid = icache_req.valid;
        s_req_addr  = icache_req.addr;
        s_acc       = (icache_req.valid === 1'b1) && c_ready;
        s_pop       = (dec_valid === 1'b1) && c_dec_ready;
        s_resp      = icache_resp.valid;
        s_dec_valid = dec_valid;
        s_dec_inst  = dec_inst;
        out_before  = pending.size();

        if (s_pop && !redir) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: dec_pc=%h dec_inst=%h, nothing expected", dec_pc, dec_inst);
            end else begin
                e = exp_q.pop_front();
                npops++;
                if (dec_pc !== e.pc || dec_inst !== e.inst || dec_fault !== e.fault) begin
                    miscompares++;
                    $display("FAIL dec_out: got pc=%h inst=%h fault=%b, want pc=%h inst=%h fault=%b",
                             dec_pc, dec_inst, dec_fault, e.pc, e.inst, e.fault);
                end
                if (is_fault(e.pc)) seen_fault = 1'b1;
            end
            if (chk_first_en) begin
                chk_first_en = 1'b0;
                vectors++;
                if (dec_pc !== chk_first_pc) begin
                    miscompares++;
                    $display("FAIL first_after_redirect: dec_pc=%h want %h", dec_pc, chk_first_pc);
                end
            end
        end

        if (s_resp) void'(pending.pop_front());

        if (redir) begin
            vectors++;
            if (icache_req.valid !== 1'b0) begin
                miscompares++;
                $display("FAIL req_during_redirect: valid=%b want 0", icache_req.valid);
            end
            case (c_sel)
                PC_BRJMP: tgt = brjmp_target;
                PC_JALR:  tgt = jalr_target;
                default:  tgt = exc_target;
            endcase
            exp_q.delete();
            m_pc = {tgt[31:2], 2'b00};
        end else if (s_acc) begin
            vectors++;
            if (icache_req.addr !== m_pc) begin
                miscompares++;
                $display("FAIL req_addr: addr=%h want %h", icache_req.addr, m_pc);
            end
            vectors++;
            if (out_before >= DEPTH) begin
                miscompares++;
                $display("FAIL credit: request accepted with %0d outstanding, limit %0d", out_before, DEPTH);
            end
            pending.push_back('{addr: m_pc, due: cyc + c_lat});
            exp_q.push_back('{pc: m_pc, inst: is_fault(m_pc) ? BUBBLE_X : mem_data(m_pc),
                              fault: is_fault(m_pc)});
            m_pc = m_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        pending.delete();
        exp_q.delete();
        icache_resp  = '0;
        m_pc         = RST_PC;
        chk_first_en = 1'b0;
        c_sel        = PC_4;
        pc_sel       = PC_4;
    endtask

    task automatic do_reset();
        assert_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        assert_reset();
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (icache_req.valid !== 1'b0 || dec_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valids: req.valid=%b dec_valid=%b want 0/0", icache_req.valid, dec_valid);
        end
        vectors++;
        if (dec_inst !== 32'h0 || dec_pc !== 32'h0 || dec_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_dec: inst=%h pc=%h fault=%b want zeros", dec_inst, dec_pc, dec_fault);
        end
        rst_n = 1'b1;
        c_ready = 1'b0;
        step();
        vectors++;
        if (s_req_valid !== 1'b1 || s_req_addr !== RST_PC) begin
            miscompares++;
            $display("FAIL first_req: valid=%b addr=%h want 1/%h", s_req_valid, s_req_addr, RST_PC);
        end
    endtask

    task automatic test_sequential();
        int p;
        do_reset();
        c_ready = 1'b1; c_lat = 1; c_dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (!s_acc || s_req_addr !== RST_PC + 32'(4 * i)) begin
                miscompares++;
                $display("FAIL seq_issue%0d: acc=%b addr=%h want 1/%h", i, s_acc, s_req_addr, RST_PC + 32'(4 * i));
            end
        end
        p = npops;
        for (int i = 0; i < 8; i++) step();
        vectors++;
        if (npops - p != 8) begin
            miscompares++;
            $display("FAIL seq_throughput: %0d pops in 8 cycles, want 8", npops - p);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        c_dec_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) held = s_dec_inst;
            vectors++;
            if (s_req_valid !== 1'b0 || s_dec_inst !== held || s_dec_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL stall%0d: req.valid=%b dec_valid=%b inst=%h want 0/1/%h",
                         i, s_req_valid, s_dec_valid, s_dec_inst, held);
            end
        end
        vectors++;
        if (exp_q.size() != 2) begin
            miscompares++;
            $display("FAIL stall_queued: %0d entries held, want 2", exp_q.size());
        end
        c_dec_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_stale_drop();
        int  n;
        logic got;
        do_reset();
        c_ready = 1'b1; c_lat = 3; c_dec_ready = 1'b1;
        n = 0;
        while (pending.size() < 2 && n < 10) begin step(); n++; end
        vectors++;
        if (pending.size() != 2) begin
            miscompares++;
            $display("FAIL stale_setup: %0d outstanding, want 2", pending.size());
        end
        brjmp_target = 32'h8000_0100;
        c_sel = PC_BRJMP;
        step();
        c_sel = PC_4;
        chk_first_en = 1'b1; chk_first_pc = 32'h8000_0100;
        got = 1'b0; n = 0;
        while (!got && n < 20) begin
            step(); n++;
            if (s_acc) got = 1'b1;
        end
        vectors++;
        if (!got || s_req_addr !== 32'h8000_0100 || n != 2) begin
            miscompares++;
            $display("FAIL stale_reissue: got=%b addr=%h after %0d cycles, want 1/80000100 after 2", got, s_req_addr, n);
        end
        for (int i = 0; i < 10; i++) step();
        vectors++;
        if (chk_first_en) begin
            miscompares++;
            $display("FAIL stale_first_pop: no instruction reached decode, want pc 80000100");
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        c_ready = 1'b1; c_lat = 1; c_dec_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        jalr_target = 32'h8000_0203;
        c_sel = PC_JALR;
        step();
        c_sel = PC_4;
        vectors++;
        if (!s_resp || !s_pop) begin
            miscompares++;
            $display("FAIL simul_setup: resp=%b pop=%b want 1/1", s_resp, s_pop);
        end
        step();
        vectors++;
        if (s_dec_valid !== 1'b0 || !s_acc || s_req_addr !== 32'h8000_0200) begin
            miscompares++;
            $display("FAIL simul_after: dec_valid=%b acc=%b addr=%h want 0/1/80000200", s_dec_valid, s_acc, s_req_addr);
        end
        chk_first_en = 1'b1; chk_first_pc = 32'h8000_0200;
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_fault();
        do_reset();
        fault_en = 1'b1; fault_addr = 32'h8000_0008;
        seen_fault = 1'b0;
        c_ready = 1'b1; c_lat = 1; c_dec_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        vectors++;
        if (!seen_fault) begin
            miscompares++;
            $display("FAIL fault_seen: faulted fetch at %h never reached decode", fault_addr);
        end
        fault_en = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        c_ready = 1'b0; c_dec_ready = 1'b0;
        step();
        vectors++;
        if (wrap_req.valid !== 1'b1 || wrap_req.addr !== WRAP_PC) begin
            miscompares++;
            $display("FAIL wrap_first: valid=%b addr=%h want 1/%h", wrap_req.valid, wrap_req.addr, WRAP_PC);
        end
        step();
        vectors++;
        if (wrap_req.valid !== 1'b1 || wrap_req.addr !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_second: valid=%b addr=%h want 1/00000000", wrap_req.valid, wrap_req.addr);
        end
    endtask

    task automatic test_async_reset();
        int p;
        do_reset();
        c_ready = 1'b1; c_lat = 1; c_dec_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        @(posedge clk);
        #2;
        vectors++;
        if (dec_valid !== 1'b1 || icache_req.valid !== 1'b1) begin
            miscompares++;
            $display("FAIL async_pre: dec_valid=%b req.valid=%b want 1/1", dec_valid, icache_req.valid);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (dec_valid !== 1'b0 || icache_req.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: dec_valid=%b req.valid=%b want 0/0", dec_valid, icache_req.valid);
        end
        do_reset();
        p = npops;
        for (int i = 0; i < 8; i++) step();
        vectors++;
        if (npops - p < 5) begin
            miscompares++;
            $display("FAIL async_recover: %0d pops after reset, want at least 5", npops - p);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_stale_drop();
        test_simultaneous();
        test_fault();
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RV32 core; sits directly upstream of decode.
- Owns the fetch PC and issues ICacheReq requests.
- Tags in-order ICacheResp responses with their PCs and buffers them in a small fetch queue feeding decode.
- Applies PC redirects from the branch unit (PcSel) and discards stale in-flight responses after a redirect.

Parameters:
- RESET_PC, 32'h8000_0000, fetch PC after reset.
- FQ_DEPTH, 2, fetch-queue entries; also the maximum outstanding cache requests.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- icache_req  out  ICacheReq  {valid, addr}
- icache_req_ready  in  1  cache accepts a request when valid&ready
- icache_resp  in  ICacheResp  {data, data_block, valid}; in order, exactly one per accepted request, ≥1 cycle after acceptance
- pc_sel  in  PcSel  redirect select from the branch unit
- brjmp_target  in  32  target for PC_BRJMP
- jalr_target  in  32  target for PC_JALR
- exc_target  in  32  target for PC_EXC
- dec_valid  out  1  fetch-queue head valid
- dec_inst  out  32  head instruction
- dec_pc  out  32  head PC
- dec_fault  out  1  head fetch faulted
- dec_ready  in  1  decode consumes the head on dec_valid&dec_ready

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values:
  - fetch_pc=RESET_PC; fetch queue and PC-tag queue empty; outstanding=0; drop=0.
  - icache_req.valid=0, dec_valid=0; dec_inst/dec_pc/dec_fault=0.
  - First cycle after rst_n rises: icache_req.valid=1, addr=RESET_PC.
  - Reset mid-operation clears all state. Responses arriving after reset are ignored while outstanding=0.
- redirect = (pc_sel != PC_4). Target is chosen by pc_sel; target[1:0] is forced to 2'b00.
- Issue:
  - icache_req.valid = !redirect && ((outstanding - drop) + count_after_pop + outstanding_live_pending... simplified: outstanding + count - pop < FQ_DEPTH), where pop = dec_valid&dec_ready in the same cycle.
  - icache_req.addr = fetch_pc.
  - On accept: push fetch_pc into the PC-tag queue, outstanding+1, fetch_pc += 4 (mod 2^32, wraps to 0).
- Response:
  - Every icache_resp.valid does outstanding−1.
  - If drop>0: drop−1 and the response is discarded.
  - Else: pop the PC-tag queue and push {inst, pc, fault} into the fetch queue.
  - If data_block=1: inst=Bubble (32'h0000_4033), fault=1. Otherwise inst=data, fault=0.
  - Credit rule guarantees no overflow; pushing to a full queue is an assertion failure.
- Decode side:
  - dec_* driven combinationally from the registered queue head.
  - Response in cycle t → visible at decode in t+1.
  - Steady state: 1 instruction/cycle with a 1-cycle cache.
  - Simultaneous push and pop is allowed at any occupancy.
- Redirect in cycle t (highest priority):
  - fetch_pc←target; fetch queue and PC-tag queue cleared.
  - drop←outstanding after cycle t's response accounting, i.e. all still-live requests become stale. A response in cycle t is discarded.
  - Any cycle-t pop is a no-op for state.
  - Request for target issued earliest in t+1.
  - Back-to-back redirects: the last one wins. drop never exceeds outstanding.
- Counter widths: $clog2(FQ_DEPTH+1). Underflow is an assertion failure.

Decomposition:
- Bundle package additions:
  - struct FetchOut {valid, inst[31:0], pc[31:0], fault}.
  - localparam FQ_DEPTH_DEFAULT.
  - Reuse ICacheReq, ICacheResp, PcSel, Bubble.
- Sub-module fetch_fifo: parameterised WIDTH/DEPTH synchronous FIFO with push, pop, flush, full, empty, and count. Instantiated twice: PC-tag queue (32b) and fetch queue (65b).

Test Plan:
- Sequential fetch:
  - Stimulus: reset release, cache ready=1, 1-cycle latency, dec_ready=1.
  - Response: requests 0x80000000, 0x80000004, 0x80000008 on consecutive cycles; decode sees the same PCs in order, one per cycle, dec_fault=0.
- Decode stall:
  - Stimulus: dec_ready=0 for 6 cycles.
  - Response: exactly 2 instructions queued; icache_req.valid=0 while full; dec_inst stable. After release, PCs continue with no gap or duplicate.
- Stale drop:
  - Stimulus: 3-cycle cache latency, 2 requests outstanding, pc_sel=PC_BRJMP, brjmp_target=0x80000100.
  - Response: both old responses discarded; first dec_pc=0x80000100; next request addr 0x80000100 only after outstanding drains below the credit limit.
- Simultaneous events:
  - Stimulus: redirect (PC_JALR, 0x80000203) in the same cycle as a response and a decode pop.
  - Response: queue empty next cycle; response dropped; next request addr 0x80000200.
- Fault:
  - Stimulus: response with data_block=1.
  - Response: dec_inst=0x00004033, dec_fault=1, correct dec_pc.
- Wrap and async reset:
  - Stimulus: RESET_PC=0xFFFFFFFC.
  - Response: second request addr 0x00000000.
  - Stimulus: rst_n asserted mid-stream between clock edges.
  - Response: dec_valid and icache_req.valid drop immediately (asynchronously).
